// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the fetch stage: icodes, status codes and the F->D register layout.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] STAT_AOK = 4'h1;
   localparam logic [3:0] STAT_HLT = 4'h2;
   localparam logic [3:0] STAT_ADR = 4'h4;
   localparam logic [3:0] STAT_INS = 4'h8;

   localparam logic [3:0] REG_NONE = 4'hF;

   typedef struct packed {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  rA;
      logic [3:0]  rB;
      logic [63:0] valC;
      logic [63:0] valP;
      logic [3:0]  stat;
      logic        pred_taken;
   } d_reg_t;

   localparam d_reg_t D_BUBBLE = '{
      icode:      I_NOP,
      ifun:       4'h0,
      rA:         REG_NONE,
      rB:         REG_NONE,
      valC:       64'h0,
      valP:       64'h0,
      stat:       STAT_AOK,
      pred_taken: 1'b0
   };

   function automatic logic has_regids(input logic [3:0] icode);
      return (icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ});
   endfunction

   function automatic logic has_valc(input logic [3:0] icode);
      return (icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL});
   endfunction

endpackage

// File: rtl/y86_instr_split.sv
// Splits a 10-byte instruction window (byte 0 in the top bits) into fields, length and validity.
module y86_instr_split
   import y86_pkg::*;
(
   input  logic [79:0] rdata_i,
   output logic [3:0]  icode_o,
   output logic [3:0]  ifun_o,
   output logic [3:0]  rA_o,
   output logic [3:0]  rB_o,
   output logic [63:0] valC_o,
   output logic [3:0]  len_o,
   output logic        valid_o
);

   logic need_regids;
   logic need_valc;

   always_comb begin
      icode_o     = rdata_i[79:76];
      ifun_o      = rdata_i[75:72];
      need_regids = has_regids(icode_o);
      need_valc   = has_valc(icode_o);

      rA_o = need_regids ? rdata_i[71:68] : REG_NONE;
      rB_o = need_regids ? rdata_i[67:64] : REG_NONE;

      // valC is little-endian, starting right after the register byte when there is one
      valC_o = 64'h0;
      if (need_valc) begin
         for (int k = 0; k < 8; k++) begin
            valC_o[8*k +: 8] = need_regids ? rdata_i[63-8*k -: 8] : rdata_i[71-8*k -: 8];
         end
      end

      len_o = 4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0);

      case (icode_o)
         I_RRMOVQ, I_JXX:                     valid_o = (ifun_o <= 4'd6);
         I_OPQ:                               valid_o = (ifun_o <= 4'd3);
         I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ,
         I_MRMOVQ, I_CALL, I_RET, I_PUSHQ,
         I_POPQ:                              valid_o = (ifun_o == 4'd0);
         default:                             valid_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/pipe_fetch_bp.sv
// Y86-64 fetch stage: PC select, branch prediction, status, and the F / F->D pipeline registers.
module pipe_fetch_bp
   import y86_pkg::*;
#(
   parameter int unsigned IMEM_BYTES = 1024,
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int unsigned PRED_MODE  = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        F_stall,
   input  logic        D_stall,
   input  logic        D_bubble,
   input  logic [3:0]  M_icode,
   input  logic        M_cnd,
   input  logic        M_pred_taken,
   input  logic [63:0] M_valA,
   input  logic [3:0]  W_icode,
   input  logic [63:0] W_valM,
   output logic [63:0] imem_addr,
   input  logic [79:0] imem_rdata,
   input  logic        imem_err,
   output logic [63:0] f_predPC,
   output logic [3:0]  D_icode,
   output logic [3:0]  D_ifun,
   output logic [3:0]  D_rA,
   output logic [3:0]  D_rB,
   output logic [63:0] D_valC,
   output logic [63:0] D_valP,
   output logic [3:0]  D_stat,
   output logic        D_pred_taken
);

   logic [63:0] F_predPC_q, F_predPC_d;
   d_reg_t      D_q, D_d;

   logic [63:0] f_pc;
   logic [3:0]  raw_icode, raw_ifun, raw_rA, raw_rB, len;
   logic [63:0] valC, valP;
   logic        instr_valid;
   logic [64:0] last_byte;
   logic        adr;
   logic [3:0]  f_icode, f_ifun, f_rA, f_rB, f_stat;
   logic        f_taken;
   d_reg_t      f_fetched;

   // ret in W beats a mispredicted jXX in M, which beats the prediction
   always_comb begin
      if (W_icode == I_RET)
         f_pc = W_valM;
      else if ((M_icode == I_JXX) && (M_cnd != M_pred_taken))
         f_pc = M_valA;
      else
         f_pc = F_predPC_q;
   end

   assign imem_addr = f_pc;

   y86_instr_split u_split (
      .rdata_i (imem_rdata),
      .icode_o (raw_icode),
      .ifun_o  (raw_ifun),
      .rA_o    (raw_rA),
      .rB_o    (raw_rB),
      .valC_o  (valC),
      .len_o   (len),
      .valid_o (instr_valid)
   );

   assign valP = f_pc + {60'h0, len};

   // 65-bit sum so a window wrapping past 2^64 still lands above IMEM_BYTES
   assign last_byte = {1'b0, f_pc} + {61'h0, len} - 65'd1;
   assign adr       = imem_err || (last_byte >= 65'(IMEM_BYTES));

   always_comb begin
      f_icode = raw_icode;
      f_ifun  = raw_ifun;
      f_rA    = raw_rA;
      f_rB    = raw_rB;
      if (adr) begin
         f_icode = I_NOP;
         f_ifun  = 4'h0;
         f_rA    = REG_NONE;
         f_rB    = REG_NONE;
         f_stat  = STAT_ADR;
      end else if (!instr_valid) begin
         f_stat  = STAT_INS;
      end else if (raw_icode == I_HALT) begin
         f_stat  = STAT_HLT;
      end else begin
         f_stat  = STAT_AOK;
      end
   end

   always_comb begin
      f_taken = (f_icode == I_JXX) && !((PRED_MODE == 1) && (valC > f_pc));
      case (f_icode)
         I_JXX:   f_predPC = f_taken ? valC : valP;
         I_CALL:  f_predPC = valC;
         I_HALT:  f_predPC = f_pc;
         default: f_predPC = valP;
      endcase
   end

   always_comb begin
      f_fetched.icode      = f_icode;
      f_fetched.ifun       = f_ifun;
      f_fetched.rA         = f_rA;
      f_fetched.rB         = f_rB;
      f_fetched.valC       = valC;
      f_fetched.stat       = f_stat;
      // a jXX carries the path it did not take, so M can recover on a mispredict
      f_fetched.valP       = (f_icode == I_JXX) ? (f_taken ? valP : valC) : valP;
      f_fetched.pred_taken = f_taken;
   end

   always_comb begin
      F_predPC_d = F_stall ? F_predPC_q : f_predPC;
      if (D_stall)
         D_d = D_q;
      else if (D_bubble)
         D_d = D_BUBBLE;
      else
         D_d = f_fetched;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         F_predPC_q <= RESET_PC;
         D_q        <= D_BUBBLE;
      end else begin
         F_predPC_q <= F_predPC_d;
         D_q        <= D_d;
      end
   end

   assign D_icode      = D_q.icode;
   assign D_ifun       = D_q.ifun;
   assign D_rA         = D_q.rA;
   assign D_rB         = D_q.rB;
   assign D_valC       = D_q.valC;
   assign D_valP       = D_q.valP;
   assign D_stat       = D_q.stat;
   assign D_pred_taken = D_q.pred_taken;

endmodule

// File: tb/tb_pipe_fetch_bp.sv
// Bench for pipe_fetch_bp: two instances (always-taken and BTFN) fed the same stimulus, scored against a model.
module tb_pipe_fetch_bp;

   localparam int IMEM = 1024;

   typedef struct packed {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  rA;
      logic [3:0]  rB;
      logic [63:0] valC;
      logic [63:0] valP;
      logic [3:0]  stat;
      logic        pred;
   } dexp_t;

   localparam dexp_t BUB = {4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 4'h1, 1'b0};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        F_stall, D_stall, D_bubble;
   logic [3:0]  M_icode, W_icode;
   logic        M_cnd, M_pred_taken, imem_err;
   logic [63:0] M_valA, W_valM;

   logic [63:0] imem_addr [2];
   logic [79:0] imem_rdata [2];
   logic [63:0] f_predPC [2];
   logic [3:0]  D_icode [2], D_ifun [2], D_rA [2], D_rB [2], D_stat [2];
   logic [63:0] D_valC [2], D_valP [2];
   logic        D_pred_taken [2];

   logic [7:0]  mem [IMEM];
   int          starts [$];
   dexp_t       q0 [$];
   dexp_t       q1 [$];
   logic [63:0] mpred [2];
   dexp_t       mdq [2];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   pipe_fetch_bp #(.IMEM_BYTES(IMEM), .RESET_PC(64'h0), .PRED_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
      .M_icode(M_icode), .M_cnd(M_cnd), .M_pred_taken(M_pred_taken), .M_valA(M_valA),
      .W_icode(W_icode), .W_valM(W_valM), .imem_addr(imem_addr[0]), .imem_rdata(imem_rdata[0]),
      .imem_err(imem_err), .f_predPC(f_predPC[0]), .D_icode(D_icode[0]), .D_ifun(D_ifun[0]),
      .D_rA(D_rA[0]), .D_rB(D_rB[0]), .D_valC(D_valC[0]), .D_valP(D_valP[0]),
      .D_stat(D_stat[0]), .D_pred_taken(D_pred_taken[0]));

   pipe_fetch_bp #(.IMEM_BYTES(IMEM), .RESET_PC(64'h0), .PRED_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
      .M_icode(M_icode), .M_cnd(M_cnd), .M_pred_taken(M_pred_taken), .M_valA(M_valA),
      .W_icode(W_icode), .W_valM(W_valM), .imem_addr(imem_addr[1]), .imem_rdata(imem_rdata[1]),
      .imem_err(imem_err), .f_predPC(f_predPC[1]), .D_icode(D_icode[1]), .D_ifun(D_ifun[1]),
      .D_rA(D_rA[1]), .D_rB(D_rB[1]), .D_valC(D_valC[1]), .D_valP(D_valP[1]),
      .D_stat(D_stat[1]), .D_pred_taken(D_pred_taken[1]));

   function automatic logic [7:0] byte_at(input logic [63:0] a);
      if (a < 64'(IMEM)) return mem[int'(a)];
      return 8'h00;
   endfunction

   function automatic logic [79:0] window(input logic [63:0] a);
      logic [79:0] w;
      for (int i = 0; i < 10; i++) w[79-8*i -: 8] = byte_at(a + 64'(i));
      return w;
   endfunction

   function automatic int regid_len(input logic [3:0] ic);
      return (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) ? 1 : 0;
   endfunction

   function automatic int valc_len(input logic [3:0] ic);
      return (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) ? 8 : 0;
   endfunction

   // Reference fetch: decode straight from the byte array and the instruction-set rules
   function automatic void model_fetch(input int mode, input logic [63:0] pc, input logic err,
                                       output dexp_t d, output logic [63:0] npc);
      logic [7:0]  b [10];
      logic [3:0]  ic, fn;
      int          rl, cl, len;
      logic [63:0] valC, valP;
      logic        ok, adr, taken;
      for (int i = 0; i < 10; i++) b[i] = byte_at(pc + 64'(i));
      ic   = b[0][7:4];
      fn   = b[0][3:0];
      rl   = regid_len(ic);
      cl   = valc_len(ic);
      len  = 1 + rl + cl;
      valC = 64'h0;
      if (cl != 0) for (int k = 0; k < 8; k++) valC[8*k +: 8] = b[1+rl+k];
      valP = pc + 64'(len);
      if (ic > 4'hB)                   ok = 1'b0;
      else if (ic == 4'h6)             ok = (fn <= 4'd3);
      else if (ic == 4'h2 || ic == 4'h7) ok = (fn <= 4'd6);
      else                             ok = (fn == 4'd0);
      adr     = err || (pc > 64'(IMEM - len));
      d.icode = ic;
      d.ifun  = fn;
      d.rA    = (rl != 0) ? b[1][7:4] : 4'hF;
      d.rB    = (rl != 0) ? b[1][3:0] : 4'hF;
      d.valC  = valC;
      if (adr) begin
         d.stat = 4'h4; d.icode = 4'h1; d.ifun = 4'h0; d.rA = 4'hF; d.rB = 4'hF;
      end else if (!ok)      d.stat = 4'h8;
      else if (ic == 4'h0)   d.stat = 4'h2;
      else                   d.stat = 4'h1;
      taken  = (d.icode == 4'h7) && !(mode == 1 && valC > pc);
      npc    = valP;
      d.valP = valP;
      d.pred = 1'b0;
      if (d.icode == 4'h7) begin
         npc    = taken ? valC : valP;
         d.valP = taken ? valP : valC;
         d.pred = taken;
      end else if (d.icode == 4'h8) npc = valC;
      else if (d.icode == 4'h0)     npc = pc;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic put(input int a, input logic [7:0] v);
      if (a < IMEM) mem[a] = v;
   endtask

   task automatic clr();
      F_stall = 0; D_stall = 0; D_bubble = 0; M_icode = 0; M_cnd = 0; M_pred_taken = 0;
      M_valA = 0; W_icode = 0; W_valM = 0; imem_err = 0;
   endtask

   // Settle, serve memory, check fetch outputs and queue the expected D contents for the next edge
   task automatic eval();
      logic [63:0] pc, np;
      dexp_t       fd, nd;
      #1;
      for (int m = 0; m < 2; m++) imem_rdata[m] = window(imem_addr[m]);
      #1;
      for (int m = 0; m < 2; m++) begin
         if (W_icode == 4'h9) pc = W_valM;
         else if (M_icode == 4'h7 && M_cnd != M_pred_taken) pc = M_valA;
         else pc = mpred[m];
         model_fetch(m, pc, imem_err, fd, np);
         chk($sformatf("imem_addr%0d", m), imem_addr[m], pc);
         chk($sformatf("f_predPC%0d", m), f_predPC[m], np);
         if (D_stall)       nd = mdq[m];
         else if (D_bubble) nd = BUB;
         else               nd = fd;
         if (m == 0) q0.push_back(nd); else q1.push_back(nd);
         mdq[m] = nd;
         if (!F_stall) mpred[m] = np;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_model();
      for (int m = 0; m < 2; m++) begin
         mpred[m] = 64'h0;
         mdq[m]   = BUB;
      end
      q0.delete();
      q1.delete();
   endtask

   // Called just after a clock edge; asserts reset mid-cycle with stalls active
   task automatic mid_reset();
      #6;
      clr();
      F_stall = 1; D_stall = 1;
      rst_n = 0;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("rst_icode%0d", m), D_icode[m], 4'h1);
         chk($sformatf("rst_rA%0d", m), D_rA[m], 4'hF);
         chk($sformatf("rst_valP%0d", m), D_valP[m], 64'h0);
         chk($sformatf("rst_stat%0d", m), D_stat[m], 4'h1);
         chk($sformatf("rst_addr%0d", m), imem_addr[m], 64'h0);
      end
      reset_model();
      @(negedge clk);
      clr();
      rst_n = 1;
   endtask

   function automatic logic [63:0] rand_target();
      case ($urandom_range(0, 9))
         0:       return {$urandom, $urandom};
         1:       return 64'(IMEM - $urandom_range(1, 12));
         2:       return 64'hFFFF_FFFF_FFFF_FFFC;
         default: return 64'(starts[$urandom_range(0, starts.size() - 1)]);
      endcase
   endfunction

   task automatic rand_inputs();
      F_stall      = ($urandom_range(0, 7) == 0);
      D_stall      = ($urandom_range(0, 7) == 0);
      D_bubble     = ($urandom_range(0, 7) == 0);
      imem_err     = ($urandom_range(0, 15) == 0);
      W_icode      = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom_range(0, 8));
      M_icode      = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
      M_cnd        = 1'($urandom_range(0, 1));
      M_pred_taken = 1'($urandom_range(0, 1));
      M_valA       = rand_target();
      W_valM       = rand_target();
   endtask

   task automatic build_mem();
      int          a, rl, cl;
      logic [3:0]  ic, fn;
      logic [63:0] vc;
      a = 0;
      while (a < IMEM) begin
         starts.push_back(a);
         ic = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) ic = 4'h7;
         fn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         rl = regid_len(ic);
         cl = valc_len(ic);
         case ($urandom_range(0, 9))
            0:       vc = {$urandom, $urandom};
            1:       vc = 64'(IMEM - $urandom_range(1, 16));
            default: vc = 64'($urandom_range(0, IMEM - 1));
         endcase
         put(a, {ic, fn});
         if (rl != 0) put(a + 1, 8'($urandom_range(0, 255)));
         for (int k = 0; k < cl; k++) put(a + 1 + rl + k, vc[8*k +: 8]);
         a += 1 + rl + cl;
      end
   endtask

   // Monitor: once per cycle, after the edge, compare each D register with the queued expectation
   initial begin
      dexp_t e, act;
      forever begin
         @(posedge clk);
         #6;
         if (q0.size() > 0) begin
            e   = q0.pop_front();
            act = {D_icode[0], D_ifun[0], D_rA[0], D_rB[0], D_valC[0], D_valP[0], D_stat[0], D_pred_taken[0]};
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL dreg0 actual=%h expected=%h", act, e);
            end
         end
         if (q1.size() > 0) begin
            e   = q1.pop_front();
            act = {D_icode[1], D_ifun[1], D_rA[1], D_rB[1], D_valC[1], D_valP[1], D_stat[1], D_pred_taken[1]};
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL dreg1 actual=%h expected=%h", act, e);
            end
         end
      end
   end

   initial begin
      logic [79:0] irm, jne;
      irm = 80'h30F3_0001_0000_0000_0000;
      jne = 80'h7440_0000_0000_0000_0000;
      imem_rdata[0] = '0;
      imem_rdata[1] = '0;
      clr();
      rst_n = 0;
      build_mem();
      for (int i = 0; i < 10; i++) put(i, irm[79-8*i -: 8]);
      for (int i = 0; i < 9; i++) put(32 + i, jne[79-8*i -: 8]);
      put(96, 8'hC0);
      for (int i = 0; i < 10; i++) put(IMEM - 5 + i, irm[79-8*i -: 8]);
      reset_model();
      #3;
      @(negedge clk);
      rst_n = 1;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("init_addr%0d", m), imem_addr[m], 64'h0);
         chk($sformatf("init_icode%0d", m), D_icode[m], 4'h1);
         chk($sformatf("init_stat%0d", m), D_stat[m], 4'h1);
         chk($sformatf("init_rA%0d", m), D_rA[m], 4'hF);
         chk($sformatf("init_rB%0d", m), D_rB[m], 4'hF);
      end

      eval(); tick();
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("irm_icode%0d", m), D_icode[m], 4'h3);
         chk($sformatf("irm_rA%0d", m), D_rA[m], 4'hF);
         chk($sformatf("irm_rB%0d", m), D_rB[m], 4'h3);
         chk($sformatf("irm_valC%0d", m), D_valC[m], 64'h100);
         chk($sformatf("irm_valP%0d", m), D_valP[m], 64'd10);
         chk($sformatf("irm_addr%0d", m), imem_addr[m], 64'd10);
      end

      W_icode = 4'h9; W_valM = 64'h20;
      eval(); tick();
      clr();
      eval();
      chk("jne_addr_btfn", imem_addr[1], 64'h29);
      chk("jne_addr_taken", imem_addr[0], 64'h40);
      chk("jne_valP_btfn", D_valP[1], 64'h40);
      chk("jne_pred_btfn", D_pred_taken[1], 1'b0);
      chk("jne_valP_taken", D_valP[0], 64'h29);
      chk("jne_pred_taken", D_pred_taken[0], 1'b1);
      tick();
      M_icode = 4'h7; M_pred_taken = 0; M_cnd = 1; M_valA = 64'h40;
      eval();
      chk("mispred_addr", imem_addr[1], 64'h40);
      tick();
      W_icode = 4'h9; W_valM = 64'h80;
      eval();
      chk("ret_wins0", imem_addr[0], 64'h80);
      chk("ret_wins1", imem_addr[1], 64'h80);
      tick();

      clr();
      F_stall = 1; D_stall = 1; D_bubble = 1;
      eval(); tick();
      eval(); tick();
      D_stall = 0;
      eval(); tick();
      chk("bubble_icode", D_icode[0], 4'h1);
      chk("bubble_stat", D_stat[1], 4'h1);

      clr();
      W_icode = 4'h9; W_valM = 64'h60;
      eval(); tick();
      chk("ins_stat0", D_stat[0], 4'h8);
      chk("ins_stat1", D_stat[1], 4'h8);
      W_valM = 64'(IMEM - 5);
      eval(); tick();
      chk("adr_stat", D_stat[0], 4'h4);
      chk("adr_icode", D_icode[1], 4'h1);
      W_valM = 64'h0; imem_err = 1;
      eval(); tick();
      chk("err_stat", D_stat[1], 4'h4);

      mid_reset();
      for (int c = 0; c < 600; c++) begin
         rand_inputs();
         eval(); tick();
      end
      mid_reset();
      for (int c = 0; c < 60; c++) begin
         rand_inputs();
         eval(); tick();
      end
      clr();
      #20;
      chk("drain0", 64'(q0.size()), 64'h0);
      chk("drain1", 64'(q1.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
